line_fill_engine: RTL and testbench

- Initiator side of the byte-wide main-memory port: Address (32b), Data (8b), isWrite, outputdata (8b).
- Takes one line-level request from the cache controller and performs it as LINE_BYTES sequential byte beats on the memory port.
  - Read: fill a line from memory.
  - Write: write back a line to memory.
- Sits between cache controller and main memory.
- Returns a one-cycle response carrying the assembled line.

---
 rtl/line_fill_pkg.sv | 25 ++
 rtl/line_fill_engine_if.sv | 37 +++
 rtl/line_fill_beat_ctr.sv | 77 +++++++
 rtl/line_fill_engine.sv | 143 ++++++++++++++
 tb/tb_line_fill_engine.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/line_fill_pkg.sv
// Shared types and helpers for the line fill engine.
// Optional build macro used by the engine: LINE_FILL_WRAP_FIRST_EN.
package line_fill_pkg;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_LINE_BYTES = 4;
  localparam int unsigned DEF_MEM_LAT    = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    DONE = 2'd2
  } lf_state_e;

  // Width of a byte offset inside a line.
  function automatic int unsigned off_width(input int unsigned line_bytes);
    return (line_bytes > 1) ? $clog2(line_bytes) : 1;
  endfunction

  // Lowest bit of byte lane `off` within a packed line.
  function automatic int unsigned lane_lsb(input int unsigned off);
    return off * 8;
  endfunction

endpackage

// File: rtl/line_fill_engine_if.sv
// Request/response and byte-wide memory port bundle of the line fill engine.
interface line_fill_engine_if
  import line_fill_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned LINE_BYTES = DEF_LINE_BYTES
);
  localparam int unsigned LINE_W = LINE_BYTES * 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] wr_line;
  logic              rsp_valid;
  logic              rsp_write;
  logic [LINE_W-1:0] rd_line;
  logic [ADDR_W-1:0] mem_address;
  logic [7:0]        mem_data;
  logic              mem_is_write;
  logic [7:0]        mem_outputdata;

  // Engine side.
  modport slave (
    input  req_valid, req_write, req_addr, wr_line, mem_outputdata,
    output req_ready, rsp_valid, rsp_write, rd_line,
           mem_address, mem_data, mem_is_write
  );

  // Cache controller / memory side.
  modport master (
    output req_valid, req_write, req_addr, wr_line, mem_outputdata,
    input  req_ready, rsp_valid, rsp_write, rd_line,
           mem_address, mem_data, mem_is_write
  );

endinterface

// File: rtl/line_fill_beat_ctr.sv
// Latency and beat counters for one line transfer; supplies current and
// next-cycle byte offset so the top can register its memory outputs.
module line_fill_beat_ctr
  import line_fill_pkg::*;
#(
  parameter  int unsigned LINE_BYTES = DEF_LINE_BYTES,
  parameter  int unsigned MEM_LAT    = DEF_MEM_LAT,
  localparam int unsigned OFF_W      = off_width(LINE_BYTES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [OFF_W-1:0] start_i,
  output logic [OFF_W-1:0] off_o,
  output logic             lat_last_o,
  output logic             beat_last_o,
  output logic [OFF_W-1:0] off_nxt_c,
  output logic             lat_last_nxt_c
);

  localparam int unsigned      LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(MEM_LAT - 1);
  localparam logic [OFF_W-1:0] BEAT_MAX = OFF_W'(LINE_BYTES - 1);

  logic [LAT_W-1:0] lat_q, lat_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic [OFF_W-1:0] start_q, start_d;
  logic [OFF_W-1:0] off_q;
  logic             lat_last_q, beat_last_q;
  logic             beat_last_d;

  // Offset arithmetic wraps naturally because LINE_BYTES is a power of two.
  always_comb begin
    lat_d   = lat_q;
    beat_d  = beat_q;
    start_d = start_q;
    if (load_i) begin
      lat_d   = '0;
      beat_d  = '0;
      start_d = start_i;
    end else if (en_i) begin
      if (lat_q == LAT_MAX) begin
        lat_d  = '0;
        beat_d = beat_q + OFF_W'(1);
      end else begin
        lat_d = lat_q + LAT_W'(1);
      end
    end
    off_nxt_c      = start_d + beat_d;
    lat_last_nxt_c = (lat_d == LAT_MAX);
    beat_last_d    = (beat_d == BEAT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_q       <= '0;
      beat_q      <= '0;
      start_q     <= '0;
      off_q       <= '0;
      lat_last_q  <= 1'b0;
      beat_last_q <= 1'b0;
    end else begin
      lat_q       <= lat_d;
      beat_q      <= beat_d;
      start_q     <= start_d;
      off_q       <= off_nxt_c;
      lat_last_q  <= lat_last_nxt_c;
      beat_last_q <= beat_last_d;
    end
  end

  assign off_o       = off_q;
  assign lat_last_o  = lat_last_q;
  assign beat_last_o = beat_last_q;

endmodule

// File: rtl/line_fill_engine.sv
// Turns one cache-line request into LINE_BYTES byte beats on the memory port.
// Define LINE_FILL_WRAP_FIRST_EN to start at the requested byte (critical first).
module line_fill_engine
  import line_fill_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned LINE_BYTES = DEF_LINE_BYTES,
  parameter int unsigned MEM_LAT    = DEF_MEM_LAT
) (
  input logic               clk,
  input logic               rst,
  line_fill_engine_if.slave bus
);

  localparam int unsigned LINE_W = LINE_BYTES * 8;
  localparam int unsigned OFF_W  = off_width(LINE_BYTES);

  lf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              write_q, write_d;
  logic [LINE_W-1:0] wr_line_q, wr_line_d;
  logic [LINE_W-1:0] rd_line_q, rd_line_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              mem_is_write_q, mem_is_write_d;

  logic             ctr_load, ctr_en;
  logic [OFF_W-1:0] start_c;
  logic [OFF_W-1:0] off, off_nxt_c;
  logic             lat_last, beat_last, lat_last_nxt_c;

`ifdef LINE_FILL_WRAP_FIRST_EN
  assign start_c = bus.req_addr[OFF_W-1:0];
`else
  assign start_c = '0;
`endif

  line_fill_beat_ctr #(
    .LINE_BYTES (LINE_BYTES),
    .MEM_LAT    (MEM_LAT)
  ) u_beat_ctr (
    .clk            (clk),
    .rst            (rst),
    .load_i         (ctr_load),
    .en_i           (ctr_en),
    .start_i        (start_c),
    .off_o          (off),
    .lat_last_o     (lat_last),
    .beat_last_o    (beat_last),
    .off_nxt_c      (off_nxt_c),
    .lat_last_nxt_c (lat_last_nxt_c)
  );

  // Next-state and request latching.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    write_d   = write_q;
    wr_line_d = wr_line_q;
    ctr_load  = 1'b0;
    ctr_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d   = BEAT;
          base_d    = bus.req_addr & ~ADDR_W'(LINE_BYTES - 1);
          write_d   = bus.req_write;
          wr_line_d = bus.wr_line;
          ctr_load  = 1'b1;
        end
      end
      BEAT: begin
        ctr_en = 1'b1;
        if (lat_last && beat_last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed for the upcoming cycle so every port is a flop.
  always_comb begin
    req_ready_d    = (state_d == IDLE);
    rsp_valid_d    = (state_d == DONE);
    rsp_write_d    = (state_d == DONE) && write_d;
    mem_address_d  = '0;
    mem_data_d     = '0;
    mem_is_write_d = 1'b0;
    if (state_d == BEAT) begin
      mem_address_d = base_d | ADDR_W'(off_nxt_c);
      if (write_d) begin
        mem_data_d     = wr_line_d[lane_lsb(32'(off_nxt_c)) +: 8];
        mem_is_write_d = lat_last_nxt_c;
      end
    end
    rd_line_d = rd_line_q;
    if ((state_q == BEAT) && !write_q && lat_last) begin
      rd_line_d[lane_lsb(32'(off)) +: 8] = bus.mem_outputdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      base_q         <= '0;
      write_q        <= 1'b0;
      wr_line_q      <= '0;
      rd_line_q      <= '0;
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_write_q    <= 1'b0;
      mem_address_q  <= '0;
      mem_data_q     <= '0;
      mem_is_write_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      write_q        <= write_d;
      wr_line_q      <= wr_line_d;
      rd_line_q      <= rd_line_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_write_q    <= rsp_write_d;
      mem_address_q  <= mem_address_d;
      mem_data_q     <= mem_data_d;
      mem_is_write_q <= mem_is_write_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_write    = rsp_write_q;
  assign bus.rd_line      = rd_line_q;
  assign bus.mem_address  = mem_address_q;
  assign bus.mem_data     = mem_data_q;
  assign bus.mem_is_write = mem_is_write_q;

endmodule

// File: tb/tb_line_fill_engine.sv
// Directed bench for line_fill_engine: MEM_LAT=1 instance with a writable
// byte memory, plus a MEM_LAT=3 instance for the top-of-address-space read.
module tb_line_fill_engine;

  logic clk;
  logic rst;
  logic mem_init;

  int checks;
  int failures;

  logic [31:0] addr_log[$];
  logic [39:0] stb_log[$];
  int          rsp_cyc;
  int          rsp_cnt;
  logic [31:0] rsp_line;
  logic        rsp_wr;
  bit          ready_bad;

  line_fill_engine_if #(.ADDR_W(32), .LINE_BYTES(4)) bus ();
  line_fill_engine_if #(.ADDR_W(32), .LINE_BYTES(4)) busb ();

  line_fill_engine #(.ADDR_W(32), .LINE_BYTES(4), .MEM_LAT(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  line_fill_engine #(.ADDR_W(32), .LINE_BYTES(4), .MEM_LAT(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (busb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory for instance A: mem[i] = i + 0x10, overwritten by write strobes.
  logic [7:0] mem_a [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 8'(i + 16);
    end else if (bus.mem_is_write) begin
      mem_a[bus.mem_address[7:0]] <= bus.mem_data;
    end
  end
  assign bus.mem_outputdata  = mem_a[bus.mem_address[7:0]];
  assign busb.mem_outputdata = busb.mem_address[7:0] + 8'h10;

  // Observation mux so one run task serves both instances.
  bit          sel_b;
  logic        o_ready, o_rsp, o_rspw, o_wr;
  logic [31:0] o_addr, o_line;
  logic [7:0]  o_data;
  assign o_ready = sel_b ? busb.req_ready    : bus.req_ready;
  assign o_rsp   = sel_b ? busb.rsp_valid    : bus.rsp_valid;
  assign o_rspw  = sel_b ? busb.rsp_write    : bus.rsp_write;
  assign o_wr    = sel_b ? busb.mem_is_write : bus.mem_is_write;
  assign o_addr  = sel_b ? busb.mem_address  : bus.mem_address;
  assign o_line  = sel_b ? busb.rd_line      : bus.rd_line;
  assign o_data  = sel_b ? busb.mem_data     : bus.mem_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request (engine must be idle) and log ncyc cycles after accept.
  task automatic run_req(input bit use_b, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wline, input int ncyc);
    sel_b = use_b;
    if (use_b) begin
      busb.req_valid = 1'b1; busb.req_write = wr; busb.req_addr = addr; busb.wr_line = wline;
    end else begin
      bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.wr_line = wline;
    end
    tick();
    bus.req_valid  = 1'b0;
    busb.req_valid = 1'b0;
    addr_log.delete();
    stb_log.delete();
    rsp_cyc   = -1;
    rsp_cnt   = 0;
    rsp_line  = '0;
    rsp_wr    = 1'b0;
    ready_bad = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (!o_ready && !o_rsp) addr_log.push_back(o_addr);
      if (o_wr) stb_log.push_back({o_addr, o_data});
      if (o_rsp) begin
        rsp_cnt++;
        if (rsp_cyc < 0) begin
          rsp_cyc  = c;
          rsp_line = o_line;
          rsp_wr   = o_rspw;
        end
      end
      if (rsp_cyc < 0 && o_ready) ready_bad = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_init = 1'b1;
    tick();
    tick();
    mem_init = 1'b0;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.rsp_write !== 1'b0) begin failures++; $display("FAIL reset_rsp_write: got %b expected 0", bus.rsp_write); end
    checks++; if (bus.rd_line !== 32'h0) begin failures++; $display("FAIL reset_rd_line: got %h expected 0", bus.rd_line); end
    checks++; if (bus.mem_address !== 32'h0 || bus.mem_data !== 8'h0 || bus.mem_is_write !== 1'b0) begin
      failures++; $display("FAIL reset_mem: got addr %h data %h wr %b expected all 0", bus.mem_address, bus.mem_data, bus.mem_is_write); end
    checks++; if (busb.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_b: got %b expected 1", busb.req_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    logic [31:0] got, exp;
    run_req(1'b0, 1'b0, 32'h6, 32'h0, 8);
    checks++; if (addr_log.size() != 4) begin failures++; $display("FAIL read_beats: got %0d expected 4", addr_log.size()); end
    for (int k = 0; k < 4; k++) begin
`ifdef LINE_FILL_WRAP_FIRST_EN
      exp = 32'h4 + 32'((2 + k) % 4);
`else
      exp = 32'h4 + 32'(k);
`endif
      got = (k < addr_log.size()) ? addr_log[k] : 32'hDEADBEEF;
      checks++; if (got !== exp) begin failures++; $display("FAIL read_addr%0d: got %h expected %h", k, got, exp); end
    end
    checks++; if (rsp_cyc != 5) begin failures++; $display("FAIL read_latency: got %0d expected 5", rsp_cyc); end
    checks++; if (rsp_cnt != 1) begin failures++; $display("FAIL read_rsp_count: got %0d expected 1", rsp_cnt); end
    checks++; if (rsp_line !== 32'h17161514) begin failures++; $display("FAIL read_line: got %h expected 17161514", rsp_line); end
    checks++; if (stb_log.size() != 0) begin failures++; $display("FAIL read_no_strobe: got %0d expected 0", stb_log.size()); end
    checks++; if (rsp_wr !== 1'b0) begin failures++; $display("FAIL read_rsp_write: got %b expected 0", rsp_wr); end
    checks++; if (ready_bad) begin failures++; $display("FAIL read_ready_low: got 1 expected 0 while busy"); end
  endtask

  task automatic test_write();
    logic [7:0]  wb [4];
    logic [39:0] got, exp;
    wb[0] = 8'hAA; wb[1] = 8'hBB; wb[2] = 8'hCC; wb[3] = 8'hDD;
    run_req(1'b0, 1'b1, 32'h8, 32'hDDCCBBAA, 8);
    checks++; if (stb_log.size() != 4) begin failures++; $display("FAIL write_strobes: got %0d expected 4", stb_log.size()); end
    for (int k = 0; k < 4; k++) begin
      exp = {32'h8 + 32'(k), wb[k]};
      got = (k < stb_log.size()) ? stb_log[k] : 40'hDEADBEEF00;
      checks++; if (got !== exp) begin failures++; $display("FAIL write_beat%0d: got %h expected %h", k, got, exp); end
    end
    checks++; if (rsp_wr !== 1'b1) begin failures++; $display("FAIL write_rsp_write: got %b expected 1", rsp_wr); end
    checks++; if (rsp_cyc != 5) begin failures++; $display("FAIL write_latency: got %0d expected 5", rsp_cyc); end
    checks++; if (bus.rd_line !== 32'h17161514) begin failures++; $display("FAIL write_rd_line_kept: got %h expected 17161514", bus.rd_line); end
    run_req(1'b0, 1'b0, 32'h8, 32'h0, 8);
    checks++; if (rsp_line !== 32'hDDCCBBAA) begin failures++; $display("FAIL readback_line: got %h expected ddccbbaa", rsp_line); end
  endtask

  task automatic test_back_to_back();
    int          cnt;
    int          cyc[2];
    logic [31:0] line2;
    logic        ready6;
    logic [31:0] addr7;
    bit          busy_bad;
    cnt = 0; cyc[0] = -1; cyc[1] = -1; line2 = '0; ready6 = 1'b0; addr7 = '0; busy_bad = 1'b0;
    sel_b = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0;
    tick();
    bus.req_addr = 32'h10;
    for (int c = 1; c <= 14; c++) begin
      if (bus.rsp_valid) begin
        if (cnt < 2) cyc[cnt] = c;
        if (cnt == 1) line2 = bus.rd_line;
        cnt++;
      end
      if (c <= 5 && bus.req_ready) busy_bad = 1'b1;
      if (c == 6) ready6 = bus.req_ready;
      if (c == 7) begin
        addr7 = bus.mem_address;
        bus.req_valid = 1'b0;
      end
      tick();
    end
    checks++; if (cnt != 2) begin failures++; $display("FAIL b2b_rsp_count: got %0d expected 2", cnt); end
    checks++; if (cyc[0] != 5) begin failures++; $display("FAIL b2b_first_rsp: got %0d expected 5", cyc[0]); end
    checks++; if (cyc[1] != 11) begin failures++; $display("FAIL b2b_second_rsp: got %0d expected 11", cyc[1]); end
    checks++; if (busy_bad) begin failures++; $display("FAIL b2b_ready_low: got 1 expected 0 while busy"); end
    checks++; if (ready6 !== 1'b1) begin failures++; $display("FAIL b2b_ready_idle: got %b expected 1", ready6); end
    checks++; if (addr7 !== 32'h10) begin failures++; $display("FAIL b2b_second_addr: got %h expected 00000010", addr7); end
    checks++; if (line2 !== 32'h23222120) begin failures++; $display("FAIL b2b_second_line: got %h expected 23222120", line2); end
  endtask

  task automatic test_reset_mid();
    bit seen_rsp;
    seen_rsp = 1'b0;
    sel_b = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0;
    tick();
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      if (bus.rsp_valid) seen_rsp = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    if (bus.rsp_valid) seen_rsp = 1'b1;
    rst = 1'b0;
    tick();
    if (bus.rsp_valid) seen_rsp = 1'b1;
    checks++; if (seen_rsp) begin failures++; $display("FAIL rstmid_no_rsp: got 1 expected 0"); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready: got %b expected 1", bus.req_ready); end
    checks++; if (bus.mem_address !== 32'h0 || bus.mem_data !== 8'h0 || bus.mem_is_write !== 1'b0) begin
      failures++; $display("FAIL rstmid_mem: got addr %h data %h wr %b expected all 0", bus.mem_address, bus.mem_data, bus.mem_is_write); end
    run_req(1'b0, 1'b0, 32'h4, 32'h0, 8);
    checks++; if (rsp_cyc != 5) begin failures++; $display("FAIL rstmid_latency: got %0d expected 5", rsp_cyc); end
    checks++; if (rsp_line !== 32'h17161514) begin failures++; $display("FAIL rstmid_line: got %h expected 17161514", rsp_line); end
  endtask

  task automatic test_lat3_top();
    logic [31:0] got, exp;
    run_req(1'b1, 1'b0, 32'hFFFFFFFD, 32'h0, 16);
    checks++; if (addr_log.size() != 12) begin failures++; $display("FAIL lat3_cycles: got %0d expected 12", addr_log.size()); end
    for (int k = 0; k < 12; k++) begin
`ifdef LINE_FILL_WRAP_FIRST_EN
      exp = 32'hFFFFFFFC + 32'((1 + k / 3) % 4);
`else
      exp = 32'hFFFFFFFC + 32'(k / 3);
`endif
      got = (k < addr_log.size()) ? addr_log[k] : 32'hDEADBEEF;
      checks++; if (got !== exp) begin failures++; $display("FAIL lat3_addr%0d: got %h expected %h", k, got, exp); end
    end
    checks++; if (rsp_cyc != 13) begin failures++; $display("FAIL lat3_latency: got %0d expected 13", rsp_cyc); end
    checks++; if (rsp_cnt != 1) begin failures++; $display("FAIL lat3_rsp_count: got %0d expected 1", rsp_cnt); end
    checks++; if (rsp_line !== 32'h0F0E0D0C) begin failures++; $display("FAIL lat3_line: got %h expected 0f0e0d0c", rsp_line); end
    checks++; if (stb_log.size() != 0) begin failures++; $display("FAIL lat3_no_strobe: got %0d expected 0", stb_log.size()); end
    sel_b = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    sel_b    = 1'b0;
    mem_init = 1'b1;
    rst      = 1'b1;
    bus.req_valid  = 1'b0; bus.req_write  = 1'b0; bus.req_addr  = '0; bus.wr_line  = '0;
    busb.req_valid = 1'b0; busb.req_write = 1'b0; busb.req_addr = '0; busb.wr_line = '0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid();
    test_lat3_top();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
